// File: rtl/mux4_rr_arbiter.sv
// mux4to1: N-bit 4:1 data selector shared by the arbiter datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the select is owned by the caller.
// Ports: A..D data in (index 0..3), S select, Y selected word.
module mux4to1 #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  input  logic [1:0]   S,
  output logic [N-1:0] Y
);

  always_comb begin
    Y = A;
    unique case (S)
      2'd0: Y = A;
      2'd1: Y = B;
      2'd2: Y = C;
      2'd3: Y = D;
      default: Y = A;
    endcase
  end

endmodule

// mux4_rr_arbiter: round-robin grant of four valid/ready requesters onto one
//   registered output word through a shared 4:1 mux.
// Latency: word accepted in cycle t is on Y with out_valid in cycle t+1.
// Backpressure: ready is held low while Y is full and not draining.
// Ports: clk, rst_n (sync, active-low); A..D + valid[3:0] in, ready[3:0] out;
//   Y, S, out_valid out with out_ready in.
module mux4_rr_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  input  logic [3:0]   valid,
  output logic [3:0]   ready,
  output logic [N-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   S
);

  logic [1:0]   ptr_q, ptr_d;
  logic [N-1:0] y_q, y_d;
  logic [1:0]   s_q, s_d;
  logic         out_valid_q, out_valid_d;

  logic [1:0]   pick;
  logic [N-1:0] mux_y;
  logic         load;

  // Search ptr+1, ptr+2, ptr+3, ptr. Walking the offsets from farthest to
  // nearest lets the nearest valid requester overwrite earlier candidates,
  // so no found-flag is needed. Offset 4 truncates to 0, i.e. ptr itself.
  always_comb begin
    logic [1:0] idx;
    pick = ptr_q;
    idx  = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr_q + k[1:0];
      if (valid[idx]) begin
        pick = idx;
      end
    end
  end

  mux4to1 #(.N(N)) u_mux (
    .A (A),
    .B (B),
    .C (C),
    .D (D),
    .S (pick),
    .Y (mux_y)
  );

  // rst_n is folded in so no requester sees a handshake during reset.
  assign load = (!out_valid_q || out_ready) && (valid != 4'b0000) && rst_n;

  always_comb begin
    ready = 4'b0000;
    if (load) begin
      ready[pick] = 1'b1;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    y_d         = y_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    if (load) begin
      ptr_d       = pick;
      y_d         = mux_y;
      s_d         = pick;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to 3 so the first search starts at A.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= 2'd3;
      y_q         <= '0;
      s_q         <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      y_q         <= y_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Y         = y_q;
  assign S         = s_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] A, B, C, D;
  logic [3:0]   valid;
  logic [3:0]   ready;
  logic [N-1:0] Y;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   S;

  int n_total;
  int n_pass;

  mux4_rr_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .valid     (valid),
    .ready     (ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_ready;
    logic        exp_ov;
    logic [31:0] exp_y;
    logic [1:0]  exp_s;
  } vec_t;

  localparam int NV = 31;
  vec_t tv [NV];

  function automatic vec_t mk(logic r, logic [3:0] v, logic o, logic [31:0] a,
                              logic [31:0] b, logic [3:0] er, logic eov,
                              logic [31:0] ey, logic [1:0] es);
    vec_t t;
    t.rst_n = r; t.valid = v; t.out_ready = o; t.a = a; t.b = b;
    t.exp_ready = er; t.exp_ov = eov; t.exp_y = ey; t.exp_s = es;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [1:0]  m_ptr;
    logic        m_ov;
    logic [31:0] m_y;
    logic        m_load;
    logic [3:0]  m_ready;
    logic [31:0] data [4];
    logic [11:0] or_pat;

    n_total = 0;
    n_pass  = 0;

    //            rst  valid    or    A          B          ready    ov    Y          S
    // reset held with all requesting
    tv[0]  = mk(1'b0, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b0000, 1'b0, 32'h0,     2'd0);
    tv[1]  = mk(1'b0, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b0000, 1'b0, 32'h0,     2'd0);
    // round-robin, all requesting, one word per cycle
    tv[2]  = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b0001, 1'b1, 32'h11,    2'd0);
    tv[3]  = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b0010, 1'b1, 32'h22,    2'd1);
    tv[4]  = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b0100, 1'b1, 32'h33,    2'd2);
    tv[5]  = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b1000, 1'b1, 32'h44,    2'd3);
    tv[6]  = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b0001, 1'b1, 32'h11,    2'd0);
    tv[7]  = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b0010, 1'b1, 32'h22,    2'd1);
    tv[8]  = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b0100, 1'b1, 32'h33,    2'd2);
    tv[9]  = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b1000, 1'b1, 32'h44,    2'd3);
    // backpressure: load A=DEAD, stall 5 cycles, then drain+load B
    tv[10] = mk(1'b1, 4'b0001, 1'b1, 32'hDEAD,  32'h22, 4'b0001, 1'b1, 32'hDEAD,  2'd0);
    tv[11] = mk(1'b1, 4'b1110, 1'b0, 32'hDEAD,  32'h22, 4'b0000, 1'b1, 32'hDEAD,  2'd0);
    tv[12] = mk(1'b1, 4'b1110, 1'b0, 32'hDEAD,  32'h22, 4'b0000, 1'b1, 32'hDEAD,  2'd0);
    tv[13] = mk(1'b1, 4'b1110, 1'b0, 32'hDEAD,  32'h22, 4'b0000, 1'b1, 32'hDEAD,  2'd0);
    tv[14] = mk(1'b1, 4'b1110, 1'b0, 32'hDEAD,  32'h22, 4'b0000, 1'b1, 32'hDEAD,  2'd0);
    tv[15] = mk(1'b1, 4'b1110, 1'b0, 32'hDEAD,  32'h22, 4'b0000, 1'b1, 32'hDEAD,  2'd0);
    tv[16] = mk(1'b1, 4'b1110, 1'b1, 32'hDEAD,  32'h22, 4'b0010, 1'b1, 32'h22,    2'd1);
    // idle with ptr=1: drain, 2 more idle cycles, then all request -> C
    tv[17] = mk(1'b1, 4'b0000, 1'b1, 32'h11,    32'h22, 4'b0000, 1'b0, 32'h22,    2'd1);
    tv[18] = mk(1'b1, 4'b0000, 1'b1, 32'h11,    32'h22, 4'b0000, 1'b0, 32'h22,    2'd1);
    tv[19] = mk(1'b1, 4'b0000, 1'b1, 32'h11,    32'h22, 4'b0000, 1'b0, 32'h22,    2'd1);
    tv[20] = mk(1'b1, 4'b1111, 1'b0, 32'h11,    32'h22, 4'b0100, 1'b1, 32'h33,    2'd2);
    // sparse / wrap: D, then C alone, then A before C
    tv[21] = mk(1'b1, 4'b1111, 1'b1, 32'h11,    32'h22, 4'b1000, 1'b1, 32'h44,    2'd3);
    tv[22] = mk(1'b1, 4'b0100, 1'b1, 32'h11,    32'h22, 4'b0100, 1'b1, 32'h33,    2'd2);
    tv[23] = mk(1'b1, 4'b0101, 1'b1, 32'h11,    32'h22, 4'b0001, 1'b1, 32'h11,    2'd0);
    // full with no request: hold
    tv[24] = mk(1'b1, 4'b0000, 1'b0, 32'h11,    32'h22, 4'b0000, 1'b1, 32'h11,    2'd0);
    // mid-operation reset: Y=55 from B, A and B pending
    tv[25] = mk(1'b1, 4'b0010, 1'b1, 32'h11,    32'h55, 4'b0010, 1'b1, 32'h55,    2'd1);
    tv[26] = mk(1'b1, 4'b0011, 1'b0, 32'h11,    32'h55, 4'b0000, 1'b1, 32'h55,    2'd1);
    tv[27] = mk(1'b0, 4'b0011, 1'b1, 32'h11,    32'h55, 4'b0000, 1'b0, 32'h0,     2'd0);
    tv[28] = mk(1'b1, 4'b0011, 1'b1, 32'h11,    32'h55, 4'b0001, 1'b1, 32'h11,    2'd0);
    tv[29] = mk(1'b1, 4'b0010, 1'b1, 32'h11,    32'h55, 4'b0010, 1'b1, 32'h55,    2'd1);
    tv[30] = mk(1'b1, 4'b0000, 1'b1, 32'h11,    32'h55, 4'b0000, 1'b0, 32'h55,    2'd1);

    rst_n = 1'b0; valid = 4'b0000; out_ready = 1'b0;
    A = 32'h11; B = 32'h22; C = 32'h33; D = 32'h44;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      rst_n     = tv[i].rst_n;
      valid     = tv[i].valid;
      out_ready = tv[i].out_ready;
      A         = tv[i].a;
      B         = tv[i].b;
      #1;
      check("ready", i, {28'd0, ready}, {28'd0, tv[i].exp_ready});
      @(posedge clk);
      #1;
      check("out_valid", i, {31'd0, out_valid}, {31'd0, tv[i].exp_ov});
      check("Y", i, Y, tv[i].exp_y);
      check("S", i, {30'd0, S}, {30'd0, tv[i].exp_s});
      @(negedge clk);
    end

    // Sustained all-request run under an irregular out_ready pattern:
    // grants must keep rotating and Y must carry the granted requester's word.
    // State entering here: ptr=1, out_valid=0.
    data[0] = 32'hA0; data[1] = 32'hB1; data[2] = 32'hC2; data[3] = 32'hD3;
    A = data[0]; B = data[1]; C = data[2]; D = data[3];
    valid  = 4'b1111;
    or_pat = 12'b1011_0010_1101;
    m_ptr  = 2'd1;
    m_ov   = 1'b0;
    m_y    = 32'h55;
    for (int i = 0; i < 12; i++) begin
      out_ready = or_pat[i];
      m_load    = !m_ov || or_pat[i];
      m_ready   = m_load ? (4'b0001 << (m_ptr + 2'd1)) : 4'b0000;
      #1;
      check("rot_ready", i, {28'd0, ready}, {28'd0, m_ready});
      @(posedge clk);
      #1;
      if (m_load) begin
        m_ptr = m_ptr + 2'd1;
        m_ov  = 1'b1;
        m_y   = data[m_ptr];
      end else if (m_ov && or_pat[i]) begin
        m_ov = 1'b0;
      end
      check("rot_ov", i, {31'd0, out_valid}, {31'd0, m_ov});
      check("rot_Y", i, Y, m_y);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one N-bit 4:1 mux datapath between four valid/ready requesters (A, B, C, D). Each cycle it picks one requester, drives the mux select and captures the selected word into a single-entry output register. Downstream consumes the word with a valid/ready handshake. The block sits in front of any shared single-port consumer and uses the team's `mux4to1` block for data selection.

## Interface
- `N`, 32, data width of every requester word and of `Y`.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `A`, `B`, `C`, `D` input N: requester data words for indices 0, 1, 2, 3.
- `valid` input 4: `valid[i]` means requester i presents a word.
- `ready` output 4: `ready[i]` means requester i's word is accepted this cycle. Combinational, one-hot or zero.
- `Y` output N: registered output word.
- `out_valid` output 1: `Y` holds a word not yet consumed.
- `out_ready` input 1: downstream accepts `Y` this cycle.
- `S` output 2: registered index of the requester whose word is in `Y`.

## Operation
- Internal state:
  - `ptr[1:0]`: last granted index.
  - Output register: `Y`, `S`, `out_valid`.
- `load = (!out_valid || out_ready) && (valid != 0) && rst_n`. The register is empty, or drains this cycle, and at least one request is pending.
- `pick` is the first index with `valid` set, searching `ptr+1`, `ptr+2`, `ptr+3`, `ptr` (mod 4). It is combinational and feeds the `S` input of the `mux4to1` instance.
- `ready[pick] = load`. All other `ready` bits are 0.
- On `load`: `Y <= mux output`, `S <= pick`, `ptr <= pick`, `out_valid <= 1`.
- On `out_valid && out_ready && !load`: `out_valid <= 0`. `Y` and `S` hold their last values.
- Otherwise the register holds, and `ptr` holds.
- Requester rules:
  - `valid[i]` and its data stay stable until `ready[i]` is seen high.
  - `valid` must not depend on `ready`.
  - A requester may drop `valid` only after a transfer completes.
- Fairness: a continuously valid requester is granted within 4 consecutive loads (at most 3 others precede it).
- Priority rotates only on an actual load. Idle cycles do not advance `ptr`.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - `out_valid = 0`, `Y = 0`, `S = 0`, `ptr = 3`. First priority after reset is A.
  - `ready` is forced to 0 in any cycle where `rst_n = 0`.
- Latency: a word accepted (`ready[i]` high) in cycle t appears on `Y` with `out_valid = 1` in cycle t+1.
- Throughput: one word per cycle while `out_ready` is held high and requests are pending.
- Full (`out_valid = 1`, `out_ready = 0`):
  - `ready = 0`.
  - `Y`, `S`, `ptr` hold.
  - No word is lost or duplicated.
- Simultaneous drain and load: the old word is consumed, the new word is written in the same edge, and `out_valid` stays 1.
- Empty with no request: `out_valid = 0`, `ready = 0`.
- `ptr` wrap-around: after index 3 the search starts at index 0.
- Reset mid-operation:
  - A word held in `Y` is discarded.
  - A requester whose `ready` was not yet seen keeps its request and re-arbitrates after reset, starting from A.
- `out_ready` is ignored while `out_valid = 0`.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `valid = 4'b1111` -> `ready = 0`, `out_valid = 0`, `Y = 0`, `S = 0`. First load after release grants A.
- Round-robin, all requesting: `valid = 1111`, A..D = 0x11, 0x22, 0x33, 0x44, `out_ready = 1` held -> `ready` sequence 0001, 0010, 0100, 1000, 0001. `Y` = 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `S` = 0, 1, 2, 3.
- Backpressure: load A = 0xDEAD, then `out_ready = 0` for 5 cycles with `valid = 1110` -> `ready = 0`, `Y = 0xDEAD`, `S = 0` stable. On `out_ready = 1`, B is granted the same cycle and `out_valid` stays 1.
- Sparse/wrap: after grant D (`ptr = 3`), `valid = 0100` only -> C granted. Then `valid = 0101` -> A granted next, not C.
- Idle hold: with `ptr = 1`, no requests for 3 cycles, then `valid = 1111` -> C granted (`ptr` did not advance while idle).
- Mid-operation reset: `out_valid = 1` with `Y = 0x55` and B still pending, assert `rst_n = 0` for 1 cycle -> `out_valid = 0`, `Y = 0`. After release, A (pending) is granted before B.
